drive_ctrl: RTL and testbench



---
 rtl/drive_pkg.sv | 36 +++
 rtl/drive_channel.sv | 155 +++++++++++++++
 rtl/drive_ctrl.sv | 60 ++++++
 tb/tb_drive_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared definitions for the N-channel motor drive controller.
// Holds command encodings, the per-channel fault state enum, H-bridge pin
// constants and the helper that maps an applied direction plus PWM to pins.
package drive_pkg;

  typedef enum logic [1:0] {
    CMD_COAST = 2'b00,
    CMD_FWD   = 2'b01,
    CMD_REV   = 2'b10,
    CMD_BRAKE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FAULT = 2'b01,
    ST_COOL  = 2'b10,
    ST_LOCK  = 2'b11
  } fstate_e;

  // H-bridge pins are {hi,lo}
  localparam logic [1:0] MOTOR_COAST = 2'b00;
  localparam logic [1:0] MOTOR_BRAKE = 2'b11;

  function automatic logic [1:0] motor_drive(input cmd_e dir, input logic pwm);
    logic [1:0] v;
    v = MOTOR_COAST;
    case (dir)
      CMD_FWD:   v = {1'b0, pwm};
      CMD_REV:   v = {pwm, 1'b0};
      CMD_BRAKE: v = MOTOR_BRAKE;
      default:   v = MOTOR_COAST;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/drive_channel.sv
// One motor channel: soft-start ramp, safe reversal, OverI synchroniser, fault FSM.
// Latency: Motor registered one cycle after internal state; OverI reaches the pins in 3 edges.
// No backpressure: free-running, driven by the shared PWM counter and wrap strobe.
// Ports: i_clk/i_rst clock and async active-high reset; i_cnt/i_wrap shared PWM counter;
//   i_cmd/i_duty channel command and target duty; i_overi async comparator; i_clear
//   lockout clear pulse; o_motor {hi,lo} pins; o_fault (FAULT/COOL); o_lockout (LOCK).
// Build option DRIVE_BRAKE_ON_FAULT_EN: brake instead of coast while faulted/locked.
module drive_channel #(
  parameter int PWM_W     = 8,
  parameter int RAMP_STEP = 16,
  parameter int RETRY_CYC = 1000,
  parameter int MAX_RETRY = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic             i_wrap,
  input  logic [1:0]       i_cmd,
  input  logic [PWM_W-1:0] i_duty,
  input  logic             i_overi,
  input  logic             i_clear,
  output logic [1:0]       o_motor,
  output logic             o_fault,
  output logic             o_lockout
);
  import drive_pkg::*;

  localparam int TW = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [PWM_W:0] STEP_X = (PWM_W+1)'(RAMP_STEP);

`ifdef DRIVE_BRAKE_ON_FAULT_EN
  localparam logic [1:0] SAFE = MOTOR_BRAKE;
`else
  localparam logic [1:0] SAFE = MOTOR_COAST;
`endif

  fstate_e          r_state;
  cmd_e             r_dir;
  logic [PWM_W-1:0] r_duty;
  logic [RW-1:0]    r_retry;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    r_okcnt;
  logic [1:0]       r_sync;
  logic [1:0]       r_motor;
  logic             r_fault;
  logic             r_lock;

  cmd_e             w_cmd;
  logic             w_ovi;
  logic             w_pwm;
  logic [RW-1:0]    w_retry_inc;
  logic [PWM_W-1:0] w_target;
  logic [PWM_W-1:0] w_ramped;
  logic [PWM_W:0]   w_diff;

  assign w_cmd       = cmd_e'(i_cmd);
  assign w_ovi       = r_sync[1];
  assign w_pwm       = (i_cnt < r_duty);
  assign w_retry_inc = r_retry + 1'b1;

  // Ramp one step toward the target, landing exactly on it when within one step.
  // A pending direction change targets zero so the old direction ramps down first.
  always_comb begin
    w_target = (r_dir == w_cmd) ? i_duty : '0;
    w_ramped = w_target;
    w_diff   = '0;
    if (r_duty < w_target) begin
      w_diff = {1'b0, w_target} - {1'b0, r_duty};
      if (w_diff > STEP_X) w_ramped = r_duty + STEP_X[PWM_W-1:0];
    end else begin
      w_diff = {1'b0, r_duty} - {1'b0, w_target};
      if (w_diff > STEP_X) w_ramped = r_duty - STEP_X[PWM_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[0], i_overi};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_dir   <= CMD_COAST;
      r_duty  <= '0;
      r_retry <= '0;
      r_timer <= '0;
      r_okcnt <= '0;
      r_motor <= MOTOR_COAST;
      r_fault <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      // A fresh synchronised fault kills the pins on this edge, before the state moves.
      r_motor <= (r_state != ST_RUN || w_ovi) ? SAFE : motor_drive(r_dir, w_pwm);
      case (r_state)
        ST_RUN: begin
          if (w_ovi) begin
            // Fault beats any ramp update landing on the same wrap.
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_duty  <= '0;
            r_okcnt <= '0;
          end else begin
            if (r_okcnt == TW'(RETRY_CYC - 1)) r_retry <= '0;
            else                               r_okcnt <= r_okcnt + 1'b1;
            if (w_cmd == CMD_COAST || w_cmd == CMD_BRAKE) begin
              r_dir  <= w_cmd;
              r_duty <= '0;
            end else if (i_wrap) begin
              r_duty <= w_ramped;
              if (r_dir != w_cmd && r_duty == '0) r_dir <= w_cmd;
            end
          end
        end
        ST_FAULT: begin
          r_retry <= w_retry_inc;
          if (w_retry_inc == RW'(MAX_RETRY)) begin
            r_state <= ST_LOCK;
            r_fault <= 1'b0;
            r_lock  <= 1'b1;
          end else begin
            r_state <= ST_COOL;
            r_timer <= TW'(RETRY_CYC - 1);
          end
        end
        ST_COOL: begin
          if (r_timer == '0) begin
            r_state <= ST_RUN;
            r_fault <= 1'b0;
            r_duty  <= '0;
            r_okcnt <= '0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_LOCK: begin
          if (i_clear && !w_ovi) begin
            r_state <= ST_RUN;
            r_lock  <= 1'b0;
            r_retry <= '0;
            r_duty  <= '0;
            r_okcnt <= '0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_motor   = r_motor;
  assign o_fault   = r_fault;
  assign o_lockout = r_lock;

endmodule

// File: rtl/drive_ctrl.sv
// N-channel motor drive controller: shared PWM counter feeding N independent channels.
// Latency: Motor registered, one cycle behind channel state.
// No backpressure: free-running; commands are sampled every cycle.
// Ports: CLK clock; RST async active-high reset; Cmd/Duty per-channel command and duty;
//   OverI async overcurrent; Clear lockout clear; Motor {hi,lo} per channel; Fault; Lockout.
// Build option DRIVE_BRAKE_ON_FAULT_EN (handled inside drive_channel).
module drive_ctrl #(
  parameter int N_CH      = 2,
  parameter int PWM_W     = 8,
  parameter int RAMP_STEP = 16,
  parameter int RETRY_CYC = 1000,
  parameter int MAX_RETRY = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2*N_CH-1:0]     Cmd,
  input  logic [PWM_W*N_CH-1:0] Duty,
  input  logic [N_CH-1:0]       OverI,
  input  logic [N_CH-1:0]       Clear,
  output logic [2*N_CH-1:0]     Motor,
  output logic [N_CH-1:0]       Fault,
  output logic [N_CH-1:0]       Lockout
);

  // Period is 2^PWM_W-1 so that duty = all-ones gives 100% on.
  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((1 << PWM_W) - 2);

  logic [PWM_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    drive_channel #(
      .PWM_W     (PWM_W),
      .RAMP_STEP (RAMP_STEP),
      .RETRY_CYC (RETRY_CYC),
      .MAX_RETRY (MAX_RETRY)
    ) u_ch (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_cnt     (r_cnt),
      .i_wrap    (w_wrap),
      .i_cmd     (Cmd[2*g +: 2]),
      .i_duty    (Duty[PWM_W*g +: PWM_W]),
      .i_overi   (OverI[g]),
      .i_clear   (Clear[g]),
      .o_motor   (Motor[2*g +: 2]),
      .o_fault   (Fault[g]),
      .o_lockout (Lockout[g])
    );
  end

endmodule

// File: tb/tb_drive_ctrl.sv
module tb_drive_ctrl;
  localparam int PWM_W = 8, RAMP_STEP = 32, RETRY_CYC = 100, MAX_RETRY = 3;
  localparam int LAST_CNT = (1 << PWM_W) - 2;
  localparam int PERIOD = LAST_CNT + 1;
  localparam int ST_R = 0, ST_F = 1, ST_C = 2, ST_L = 3;
`ifdef DRIVE_BRAKE_ON_FAULT_EN
  localparam logic [1:0] SF = 2'b11;
`else
  localparam logic [1:0] SF = 2'b00;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  Cmd;
  logic [15:0] Duty;
  logic [1:0]  OverI, Clear;
  logic [3:0]  Motor;
  logic [1:0]  Fault, Lockout;

  drive_ctrl #(.N_CH(2), .PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP),
               .RETRY_CYC(RETRY_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK(CLK), .RST(RST), .Cmd(Cmd), .Duty(Duty), .OverI(OverI), .Clear(Clear),
    .Motor(Motor), .Fault(Fault), .Lockout(Lockout));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0;

  // Behavioural reference: per-channel quantities as plain integers.
  int m_cnt;
  int m_duty[2], m_dir[2], m_st[2], m_retry[2], m_timer[2], m_clean[2];
  bit m_s0[2], m_s1[2], m_fault[2], m_lock[2];
  logic [1:0] m_motor[2];

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 0; m_dir[c] = 0; m_st[c] = ST_R; m_retry[c] = 0; m_timer[c] = 0;
      m_clean[c] = 0; m_s0[c] = 0; m_s1[c] = 0; m_fault[c] = 0; m_lock[c] = 0;
      m_motor[c] = 2'b00;
    end
  endtask

  task automatic model_step();
    bit wrap, pwm;
    int cmd, tgt;
    wrap = (m_cnt == LAST_CNT);
    for (int c = 0; c < 2; c++) begin
      cmd = int'(Cmd[2*c +: 2]);
      tgt = int'(Duty[8*c +: 8]);
      pwm = (m_cnt < m_duty[c]);
      if (m_st[c] != ST_R || m_s1[c]) m_motor[c] = SF;
      else if (m_dir[c] == 1) m_motor[c] = {1'b0, pwm};
      else if (m_dir[c] == 2) m_motor[c] = {pwm, 1'b0};
      else if (m_dir[c] == 3) m_motor[c] = 2'b11;
      else m_motor[c] = 2'b00;
      case (m_st[c])
        ST_R: if (m_s1[c]) begin
          m_st[c] = ST_F; m_duty[c] = 0; m_clean[c] = 0;
        end else begin
          m_clean[c]++;
          if (m_clean[c] >= RETRY_CYC) m_retry[c] = 0;
          if (cmd == 0 || cmd == 3) begin
            m_dir[c] = cmd; m_duty[c] = 0;
          end else if (wrap) begin
            if (m_dir[c] != cmd) begin
              if (m_duty[c] == 0) m_dir[c] = cmd;
              else m_duty[c] = (m_duty[c] > RAMP_STEP) ? m_duty[c] - RAMP_STEP : 0;
            end else if (m_duty[c] < tgt) begin
              m_duty[c] = (m_duty[c] + RAMP_STEP < tgt) ? m_duty[c] + RAMP_STEP : tgt;
            end else begin
              m_duty[c] = (m_duty[c] - RAMP_STEP > tgt) ? m_duty[c] - RAMP_STEP : tgt;
            end
          end
        end
        ST_F: begin
          m_retry[c]++;
          if (m_retry[c] == MAX_RETRY) m_st[c] = ST_L;
          else begin m_st[c] = ST_C; m_timer[c] = RETRY_CYC - 1; end
        end
        ST_C: if (m_timer[c] == 0) begin
          m_st[c] = ST_R; m_duty[c] = 0; m_clean[c] = 0;
        end else m_timer[c]--;
        default: if (Clear[c] && !m_s1[c]) begin
          m_st[c] = ST_R; m_retry[c] = 0; m_duty[c] = 0; m_clean[c] = 0;
        end
      endcase
      m_fault[c] = (m_st[c] == ST_F || m_st[c] == ST_C);
      m_lock[c]  = (m_st[c] == ST_L);
      m_s1[c] = m_s0[c];
      m_s0[c] = OverI[c];
    end
    m_cnt = wrap ? 0 : m_cnt + 1;
  endtask

  task automatic expect_vals(input string tag, input logic [3:0] em,
                             input logic [1:0] ef, input logic [1:0] el);
    n_cmp++;
    if (Motor !== em || Fault !== ef || Lockout !== el) begin
      n_err++;
      $display("FAIL %s t=%0t: got Motor=%b Fault=%b Lockout=%b, want %b %b %b",
               tag, $time, Motor, Fault, Lockout, em, ef, el);
    end
  endtask

  task automatic expect_int(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0d, want %0d", tag, $time, act, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    expect_vals(tag, {m_motor[1], m_motor[0]}, {m_fault[1], m_fault[0]},
                {m_lock[1], m_lock[0]});
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #2 RST = 1'b1;
    #1 expect_vals("async_reset", 4'b0000, 2'b00, 2'b00);
    model_reset();
    #1 RST = 1'b0;
  endtask

  task automatic run_window(input string tag, output int lo, output int hi);
    lo = 0; hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      tick(tag);
      lo += int'(Motor[0]);
      hi += int'(Motor[1]);
    end
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [15:0] duty;
    logic [1:0]  ovi;
    logic [1:0]  clr;
    int          ncyc;
    logic [3:0]  motor;
    logic [1:0]  fault;
    logic [1:0]  lock;
  } vec_t;

  vec_t tbl[12];
  int exp_lo[8] = '{128, 96, 64, 32, 0, 0, 0, 0};
  int exp_hi[8] = '{0, 0, 0, 0, 0, 0, 32, 64};
  int hold[2] = '{0, 0};

  initial begin
    int lo, hi, g;
    RST = 1'b1; Cmd = '0; Duty = '0; OverI = '0; Clear = '0;
    model_reset();
    tbl[0]  = '{4'b0000, 16'h0000, 2'b00, 2'b00, 2,    4'b0000,       2'b00, 2'b00};
    tbl[1]  = '{4'b1100, 16'h0000, 2'b00, 2'b00, 2,    4'b1100,       2'b00, 2'b00};
    tbl[2]  = '{4'b0000, 16'h0000, 2'b00, 2'b00, 2,    4'b0000,       2'b00, 2'b00};
    tbl[3]  = '{4'b0001, 16'h00FF, 2'b00, 2'b00, 2400, 4'b0001,       2'b00, 2'b00};
    tbl[4]  = '{4'b0001, 16'h00FF, 2'b01, 2'b00, 3,    {2'b00, SF},   2'b01, 2'b00};
    tbl[5]  = '{4'b0001, 16'h00FF, 2'b00, 2'b00, 101,  {2'b00, SF},   2'b00, 2'b00};
    tbl[6]  = '{4'b0001, 16'h00FF, 2'b01, 2'b00, 300,  {2'b00, SF},   2'b00, 2'b01};
    tbl[7]  = '{4'b0001, 16'h00FF, 2'b01, 2'b01, 1,    {2'b00, SF},   2'b00, 2'b01};
    tbl[8]  = '{4'b0001, 16'h00FF, 2'b00, 2'b00, 3,    {2'b00, SF},   2'b00, 2'b01};
    tbl[9]  = '{4'b0001, 16'h00FF, 2'b00, 2'b01, 1,    {2'b00, SF},   2'b00, 2'b00};
    tbl[10] = '{4'b0001, 16'h00FF, 2'b00, 2'b00, 2,    4'b0000,       2'b00, 2'b00};
    tbl[11] = '{4'b1110, 16'h00FF, 2'b00, 2'b00, 2,    4'b1100,       2'b00, 2'b00};

    repeat (2) @(negedge CLK);
    expect_vals("reset_state", 4'b0000, 2'b00, 2'b00);
    RST = 1'b0;

    // Directed table from reset: brake, full ramp, fault/retry, lockout and clear.
    for (int r = 0; r < 12; r++) begin
      Cmd = tbl[r].cmd; Duty = tbl[r].duty; OverI = tbl[r].ovi; Clear = tbl[r].clr;
      for (int k = 0; k < tbl[r].ncyc; k++) tick($sformatf("row%0d_cyc", r));
      expect_vals($sformatf("row%0d", r), tbl[r].motor, tbl[r].fault, tbl[r].lock);
    end

    // Reversal: ramp ch0 to 128 FWD, then request REV and measure each PWM period.
    Cmd = 4'b1101; Duty = 16'h0080; OverI = '0; Clear = '0;
    g = 0;
    while (m_cnt != 0 && g < 2 * PERIOD) begin tick("align"); g++; end
    for (int w = 0; w < 6; w++) run_window("ramp_up", lo, hi);
    run_window("fwd128", lo, hi);
    expect_int("fwd128_lo", lo, 128);
    expect_int("fwd128_hi", hi, 0);
    Cmd = 4'b1110;
    for (int w = 0; w < 8; w++) begin
      run_window("reverse", lo, hi);
      expect_int($sformatf("rev_w%0d_lo", w), lo, exp_lo[w]);
      expect_int($sformatf("rev_w%0d_hi", w), hi, exp_hi[w]);
    end

    // Reset during cool-down, then confirm the retry count restarted from zero.
    OverI = 2'b01; tick("pulse");
    OverI = 2'b00;
    repeat (29) tick("cool");
    expect_int("cool_fault0", int'(Fault[0]), 1);
    expect_int("cool_motor1", int'(Motor[3:2]), 3);
    pulse_reset();
    OverI = 2'b01;
    repeat (150) tick("retry0");
    expect_int("retry0_nolock", int'(Lockout[0]), 0);
    expect_int("retry0_fault", int'(Fault[0]), 1);
    repeat (60) tick("retry0b");
    expect_int("retry0_lock", int'(Lockout[0]), 1);
    OverI = 2'b00;
    repeat (3) tick("flush");
    Clear = 2'b01; tick("clear");
    Clear = 2'b00; tick("after_clear");
    expect_int("unlocked", int'(Lockout[0]), 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 12000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 299) == 0) begin
          Cmd[2*c +: 2]  = 2'($urandom_range(0, 3));
          Duty[8*c +: 8] = 8'($urandom_range(0, 255));
        end
        if (hold[c] > 0) hold[c]--;
        else if ($urandom_range(0, 1499) == 0) hold[c] = $urandom_range(1, 4);
        OverI[c] = (hold[c] > 0) || (c == 1 && i >= 3000 && i < 3400);
        Clear[c] = ($urandom_range(0, 199) == 0);
      end
      tick("random");
      if (i == 7000) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
